tdm_burst_reader: RTL

TDM_BURST_READER -- requirements
Module: tdm_burst_reader

---
 rtl/tdm_pkg.sv | 15 +
 rtl/tdm_skid.sv | 42 ++++
 rtl/tdm_burst_reader.sv | 102 ++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared types for the TDM burst reader
//   state_t      : reader FSM states
//   skid_entry_t : one buffered output word with its channel tag and burst flags;
//                  data/chan are sized for the widest supported configuration
package tdm_pkg;
   localparam int TDM_DATA_MAX = 32;
   localparam int TDM_CHAN_MAX = 8;
   typedef enum logic [1:0] {IDLE, SELECT, READ, DRAIN} state_t;
   typedef struct packed {
      logic [TDM_DATA_MAX-1:0] data;
      logic [TDM_CHAN_MAX-1:0] chan;
      logic                    sof;
      logic                    eof;
   } skid_entry_t;
endpackage

// File: rtl/tdm_skid.sv
// tdm_skid: 2-entry valid/ready skid buffer, head entry drives the outputs
//   push/din  : write one entry this cycle
//   ready     : downstream accepts head when valid
//   valid     : head entry present
//   head      : oldest entry
//   occ       : number of stored entries (0..2)
module tdm_skid
   import tdm_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        push,
   input  skid_entry_t din,
   input  logic        ready,
   output logic        valid,
   output skid_entry_t head,
   output logic [1:0]  occ
);
   skid_entry_t e0_q, e0_d, e1_q, e1_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        pop;
   always_comb begin
      pop   = (cnt_q != 2'd0) && ready;
      cnt_d = cnt_q + 2'(push) - 2'(pop);
      // head refills from the second slot when full, else straight from the incoming word
      e0_d  = (pop && cnt_q == 2'd2) ? e1_q : ((pop || cnt_q == 2'd0) && push) ? din : e0_q;
      e1_d  = (push && cnt_d == 2'd2) ? din : e1_q;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         e0_q  <= '0;
         e1_q  <= '0;
         cnt_q <= '0;
      end else begin
         e0_q  <= e0_d;
         e1_q  <= e1_d;
         cnt_q <= cnt_d;
      end
   assign valid = cnt_q != 2'd0;
   assign head  = e0_q;
   assign occ   = cnt_q;
endmodule

// File: rtl/tdm_burst_reader.sv
// tdm_burst_reader: round-robin TDM reader moving bursts from channel FIFOs to one stream
//   fifo_count : per-channel occupancy, sampled only in SELECT
//   fifo_ren   : one-hot read strobe, data returns on fifo_dout one cycle later
//   tx_*       : valid/ready output stream with channel tag and burst sof/eof
module tdm_burst_reader
   import tdm_pkg::*;
#(
   parameter int NCH       = 4,
   parameter int WIDTH     = 8,
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 5
)(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NCH*CNT_W-1:0]   fifo_count,
   output logic [NCH-1:0]         fifo_ren,
   input  logic [NCH*WIDTH-1:0]   fifo_dout,
   output logic                   tx_valid,
   input  logic                   tx_ready,
   output logic [WIDTH-1:0]       tx_data,
   output logic [$clog2(NCH)-1:0] tx_chan,
   output logic                   tx_sof,
   output logic                   tx_eof
);
   localparam int CHW = $clog2(NCH);
   localparam int LW  = $clog2(BURST_LEN + 1);
   state_t         state_q, state_d;
   logic [CHW-1:0] slot_q, slot_d, slot_nxt;
   logic [LW-1:0]  len_q, len_d, iss_q, iss_d, rcv_q, rcv_d;
   logic           infl_q, infl_d;
   logic [CNT_W-1:0] cnt;
   logic           pop, rd;
   logic [1:0]     occ;
   skid_entry_t    push_e, head;
   logic           unused_head;
   always_comb begin
      cnt         = fifo_count[slot_q*CNT_W +: CNT_W];
      pop         = tx_valid && tx_ready;
      // skid + in-flight after this cycle's pop must stay below 2 so a returning word always fits
      rd          = state_q == READ && iss_q != len_q && 3'(occ) + 3'(infl_q) < 3'd2 + 3'(pop);
      fifo_ren    = rd ? NCH'(1) << slot_q : '0;
      slot_nxt    = slot_q == CHW'(NCH - 1) ? '0 : slot_q + 1'b1;
      push_e      = '0;
      push_e.data = TDM_DATA_MAX'(fifo_dout[slot_q*WIDTH +: WIDTH]);
      push_e.chan = TDM_CHAN_MAX'(slot_q);
      push_e.sof  = rcv_q == '0;
      push_e.eof  = rcv_q + 1'b1 == len_q;
      state_d     = state_q;
      slot_d      = slot_q;
      len_d       = len_q;
      iss_d       = iss_q + LW'(rd);
      rcv_d       = rcv_q + LW'(infl_q);
      infl_d      = rd;
      case (state_q)
         IDLE:   state_d = SELECT;
         SELECT: begin
            len_d = (32'(cnt) > BURST_LEN) ? LW'(BURST_LEN) : LW'(cnt);
            iss_d = '0;
            rcv_d = '0;
            if (len_d == '0) slot_d = slot_nxt;
            else state_d = READ;
         end
         READ:   if (iss_d == len_q) state_d = DRAIN;
         DRAIN:  if (pop && head.eof) begin
            state_d = SELECT;
            slot_d  = slot_nxt;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         slot_q  <= '0;
         len_q   <= '0;
         iss_q   <= '0;
         rcv_q   <= '0;
         infl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         slot_q  <= slot_d;
         len_q   <= len_d;
         iss_q   <= iss_d;
         rcv_q   <= rcv_d;
         infl_q  <= infl_d;
      end
   tdm_skid u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (infl_q),
      .din   (push_e),
      .ready (tx_ready),
      .valid (tx_valid),
      .head  (head),
      .occ   (occ)
   );
   assign tx_data     = head.data[WIDTH-1:0];
   assign tx_chan     = head.chan[CHW-1:0];
   assign tx_sof      = head.sof;
   assign tx_eof      = head.eof;
   assign unused_head = ^{head.data, head.chan};
endmodule
